// File: rtl/dsm_cifb_cfg.sv
// dsm_cifb_cfg: configurable single-bit delta-sigma modulator (1st/2nd order).
// Turns a W-bit unsigned control word into a 1-bit stream whose ones-density
// is alpha/2^W. Integrators saturate to W+GUARD bits. Clamp events are
// reported. A change of order_sel forces a one-clock flush to zero state.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   en         sample strobe; the modulator advances only when en=1
//   alpha      unsigned input word
//   order_sel  0 = 1st order, 1 = 2nd order
//   dither_en  add +/-1 LSB LFSR dither at the integrator 1 input
//   ovl_clr    clears ovl and ovl_cnt (a clamp in the same cycle wins)
//   dout       modulator bit
//   dout_vld   one-cycle pulse after each accepted en
//   busy       high during the flush cycle
//   ovl        sticky clamp flag
//   ovl_cnt    saturating count of en-steps that clamped
module dsm_cifb_cfg #(
    parameter int          W         = 16,
    parameter int          GUARD     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] alpha,
    input  logic         order_sel,
    input  logic         dither_en,
    input  logic         ovl_clr,
    output logic         dout,
    output logic         dout_vld,
    output logic         busy,
    output logic         ovl,
    output logic [15:0]  ovl_cnt
);

    localparam int IW = W + GUARD;   // integrator width
    localparam int SW = IW + 2;      // width of the intermediate sums

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic signed [SW-1:0] HALF = {{(SW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic signed [SW-1:0] ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] MAXV = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-IW+1){1'b1}}, {(IW-1){1'b0}}};

    logic [0:0]           state;
    logic                 active_order;
    logic signed [IW-1:0] x1, x2;
    logic [15:0]          lfsr;

    logic signed [SW-1:0] x1_ext, x2_ext, u_ext, d_ext, y_ext, s1, s2;
    logic signed [IW-1:0] x1_nxt, x2_nxt;
    logic                 clamp1, clamp2, clamp, accept, lfsr_fb;

    assign busy = (state == FLUSH);

    always_comb begin
        x1_ext = {{2{x1[IW-1]}}, x1};
        x2_ext = {{2{x2[IW-1]}}, x2};
        u_ext  = $signed({{(SW-W){1'b0}}, alpha}) - HALF;
        if (!dither_en)   d_ext = '0;
        else if (lfsr[0]) d_ext = ONE;
        else              d_ext = '1;
        y_ext  = dout ? HALF : -HALF;

        s1 = x1_ext + u_ext + d_ext - y_ext;
        s2 = x2_ext + x1_ext - y_ext - y_ext;

        clamp1 = (s1 > MAXV) || (s1 < MINV);
        if (s1 > MAXV)      x1_nxt = MAXV[IW-1:0];
        else if (s1 < MINV) x1_nxt = MINV[IW-1:0];
        else                x1_nxt = s1[IW-1:0];

        clamp2 = (s2 > MAXV) || (s2 < MINV);
        if (s2 > MAXV)      x2_nxt = MAXV[IW-1:0];
        else if (s2 < MINV) x2_nxt = MINV[IW-1:0];
        else                x2_nxt = s2[IW-1:0];

        // integrator 2 only exists (and can only clamp) in 2nd order
        clamp   = clamp1 | (active_order & clamp2);
        lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        accept  = (state == RUN) && (order_sel == active_order) && en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            active_order <= order_sel;
            x1           <= '0;
            x2           <= '0;
            dout         <= 1'b0;
            dout_vld     <= 1'b0;
            ovl          <= 1'b0;
            ovl_cnt      <= '0;
            lfsr         <= LFSR_SEED;
        end else begin
            dout_vld <= 1'b0;
            if (state == FLUSH) begin
                state <= RUN;
            end else if (order_sel != active_order) begin
                // order change pre-empts any strobe in this cycle
                state        <= FLUSH;
                active_order <= order_sel;
                x1           <= '0;
                x2           <= '0;
                dout         <= 1'b0;
            end else if (en) begin
                x1       <= x1_nxt;
                lfsr     <= {lfsr[14:0], lfsr_fb};
                dout_vld <= 1'b1;
                if (active_order) begin
                    x2   <= x2_nxt;
                    dout <= ~x2_nxt[IW-1];
                end else begin
                    x2   <= '0;
                    dout <= ~x1_nxt[IW-1];
                end
            end

            if (accept && clamp) begin
                ovl     <= 1'b1;
                ovl_cnt <= ovl_clr ? 16'd1 :
                           (ovl_cnt == 16'hFFFF) ? ovl_cnt : ovl_cnt + 16'd1;
            end else if (ovl_clr) begin
                ovl     <= 1'b0;
                ovl_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dsm_cifb_cfg.sv
// Bench for dsm_cifb_cfg: two instances (GUARD=4 and GUARD=1) driven with the
// same stimulus and compared every cycle against an integer reference model.
module tb_dsm_cifb_cfg;

    logic        clk = 1'b0;
    logic        reset, en, order_sel, dither_en, ovl_clr;
    logic [15:0] alpha;
    logic        dout, dout_vld, busy, ovl;
    logic [15:0] ovl_cnt;
    logic        dout_g, dout_vld_g, busy_g, ovl_g;
    logic [15:0] ovl_cnt_g;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dsm_cifb_cfg #(.W(16), .GUARD(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .en(en), .alpha(alpha), .order_sel(order_sel),
        .dither_en(dither_en), .ovl_clr(ovl_clr), .dout(dout), .dout_vld(dout_vld),
        .busy(busy), .ovl(ovl), .ovl_cnt(ovl_cnt)
    );

    dsm_cifb_cfg #(.W(16), .GUARD(1), .LFSR_SEED(16'hACE1)) dut_g (
        .clk(clk), .reset(reset), .en(en), .alpha(alpha), .order_sel(order_sel),
        .dither_en(dither_en), .ovl_clr(ovl_clr), .dout(dout_g), .dout_vld(dout_vld_g),
        .busy(busy_g), .ovl(ovl_g), .ovl_cnt(ovl_cnt_g)
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model (index 0: GUARD=4, 1: GUARD=1) -------
    longint m_x1[2], m_x2[2];
    bit     m_dout[2], m_ovl[2];
    int     m_cnt[2];
    int     m_lfsr;
    bit     m_ord, m_busy, m_vld;

    function automatic longint sat(input longint v, input longint lim, output bit c);
        c = (v > lim - 1) || (v < -lim);
        if (v > lim - 1) return lim - 1;
        if (v < -lim)    return -lim;
        return v;
    endfunction

    task automatic model_step();
        bit     acc, c1, c2, clampk;
        longint u, d, y, lim, nx1, nx2;
        int     a;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_x1[k] = 0; m_x2[k] = 0; m_dout[k] = 0; m_ovl[k] = 0; m_cnt[k] = 0;
            end
            m_lfsr = 'hACE1; m_ord = order_sel; m_busy = 0; m_vld = 0;
            return;
        end
        acc = 0;
        if (m_busy) m_busy = 0;
        else if (order_sel != m_ord) begin
            m_busy = 1; m_ord = order_sel;
            for (int k = 0; k < 2; k++) begin
                m_x1[k] = 0; m_x2[k] = 0; m_dout[k] = 0;
            end
        end else if (en) acc = 1;

        a = alpha;
        for (int k = 0; k < 2; k++) begin
            clampk = 0;
            if (acc) begin
                lim = 64'sd1 << (15 + ((k == 0) ? 4 : 1));
                u = a - 32768;
                d = dither_en ? (((m_lfsr & 1) != 0) ? 1 : -1) : 0;
                y = m_dout[k] ? 32768 : -32768;
                nx1 = sat(m_x1[k] + u + d - y, lim, c1);
                if (m_ord) begin
                    nx2 = sat(m_x2[k] + m_x1[k] - 2 * y, lim, c2);
                    m_dout[k] = (nx2 >= 0);
                end else begin
                    nx2 = 0; c2 = 0;
                    m_dout[k] = (nx1 >= 0);
                end
                m_x1[k] = nx1; m_x2[k] = nx2;
                clampk = c1 | c2;
            end
            if (clampk) begin
                m_ovl[k] = 1;
                m_cnt[k] = ovl_clr ? 1 : ((m_cnt[k] == 65535) ? 65535 : m_cnt[k] + 1);
            end else if (ovl_clr) begin
                m_ovl[k] = 0; m_cnt[k] = 0;
            end
        end
        if (acc)
            m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^
                     (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 'hFFFF;
        m_vld = acc;
    endtask

    task automatic compare_all();
        check("dout",      dout,       m_dout[0]);
        check("dout_g",    dout_g,     m_dout[1]);
        check("vld",       dout_vld,   m_vld);
        check("vld_g",     dout_vld_g, m_vld);
        check("busy",      busy,       m_busy);
        check("busy_g",    busy_g,     m_busy);
        check("ovl",       ovl,        m_ovl[0]);
        check("ovl_g",     ovl_g,      m_ovl[1]);
        check("ovl_cnt",   ovl_cnt,    m_cnt[0]);
        check("ovl_cnt_g", ovl_cnt_g,  m_cnt[1]);
        check("x1",        dut.x1,     m_x1[0]);
        check("x2",        dut.x2,     m_x2[0]);
        check("x1_g",      dut_g.x1,   m_x1[1]);
        check("x2_g",      dut_g.x2,   m_x2[1]);
        check("lfsr",      dut.lfsr,   m_lfsr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input bit ord, input int cycles);
        reset = 1; order_sel = ord; en = 1; ovl_clr = 0; dither_en = 0;
        for (int i = 0; i < cycles; i++) tick();
        reset = 0;
    endtask

    int ones, pulses;

    initial begin
        alpha = 16'h1234; reset = 1; en = 1; order_sel = 0; dither_en = 0; ovl_clr = 0;

        // reset state
        do_reset(0, 2);
        check("rst_lfsr", dut.lfsr, 16'hACE1);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);

        // order 1, mid-scale: 1,1,0,1,0,...
        alpha = 16'h8000;
        tick(); check("t2_step1", dout, 1); check("t2_x1_1", dut.x1, 32768);
        tick(); check("t2_step2", dout, 1); check("t2_x1_2", dut.x1, 0);
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            ones += dout;
        end
        check("t2_ones64", ones, 32);

        // order 2, 3/4 scale with dither
        do_reset(1, 2);
        alpha = 16'hC000; dither_en = 1; ones = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            ones += dout;
        end
        check("t3_ones_in_768pm3", (ones >= 765 && ones <= 771), 1);
        check("t3_ovl", ovl, 0);

        // 1-in-4 strobes, order 2, 1/4 scale
        do_reset(1, 1);
        alpha = 16'h4000; ones = 0; pulses = 0;
        for (int i = 0; i < 4096; i++) begin
            en = ((i % 4) == 0);
            tick();
            pulses += dout_vld;
            if (dout_vld) ones += dout;
        end
        check("t4_pulses", pulses, 1024);
        check("t4_density", (ones >= 246 && ones <= 266), 1);

        // overload on the GUARD=1 instance
        do_reset(1, 1);
        alpha = 16'hFFFF; en = 1;
        for (int i = 0; i < 256; i++) begin
            tick();
            check("t5_x1_range", (dut_g.x1 >= -65536 && dut_g.x1 <= 65535), 1);
            check("t5_x2_range", (dut_g.x2 >= -65536 && dut_g.x2 <= 65535), 1);
        end
        check("t5_ovl", ovl_g, 1);
        check("t5_cnt_nz", (ovl_cnt_g > 0), 1);
        en = 0; ovl_clr = 1;
        tick();
        ovl_clr = 0;
        check("t5_clr_ovl", ovl_g, 0);
        check("t5_clr_cnt", ovl_cnt_g, 0);

        // order change flush, then reset during flush
        do_reset(1, 1);
        alpha = 16'h6000; en = 1;
        for (int i = 0; i < 20; i++) tick();
        order_sel = 0;
        tick();
        check("t6_busy", busy, 1); check("t6_dout", dout, 0); check("t6_vld", dout_vld, 0);
        check("t6_x1", dut.x1, 0); check("t6_x2", dut.x2, 0);
        alpha = 16'h8000;
        tick();
        check("t6_busy_end", busy, 0); check("t6_vld_ign", dout_vld, 0);
        tick();
        check("t6_resume_x1", dut.x1, 32768); check("t6_resume_vld", dout_vld, 1);
        order_sel = 1;
        tick();
        check("t6_busy2", busy, 1);
        reset = 1;
        tick();
        reset = 0;
        check("t6_rst_busy", busy, 0); check("t6_rst_lfsr", dut.lfsr, 16'hACE1);

        // randomized mix
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 2) != 0);
            alpha     = 16'($urandom);
            dither_en = 1'($urandom);
            ovl_clr   = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 63) == 0) order_sel = ~order_sel;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
